// File: rtl/fetcher_icache.sv
// fetcher_icache: instruction fetch stage with a direct-mapped, one-word-per-line
// instruction cache in front of the memory controller's fetcher port.
//
// Holds the fetch PC and looks it up every cycle in IDLE. A hit delivers one
// instruction per cycle to issue. A miss sends one word request and waits for
// the fill, after which the same PC is looked up again and hits. A ROB
// misbranch redirects the PC and abandons any outstanding request.
//
// Build option FETCHER_ICACHE_EN:
//   defined   - ICACHE_LINES-entry direct-mapped cache
//   undefined - a single line buffer (tag = pc[17:2]); ICACHE_LINES is ignored
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes every register
//   out_mem_ce/addr   one-cycle word request; address held until fill or flush
//   in_mem_ce/data    one-cycle fill completion with the fetched word
//   in_issue_stall    downstream cannot take an instruction this cycle
//   out_inst_valid    one-cycle delivery pulse with out_inst / out_inst_pc
//   in_rob_misbranch  flush and redirect to in_rob_newpc
module fetcher_icache #(
  parameter int unsigned ICACHE_LINES = 256,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        out_mem_ce,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ce,
  input  logic [31:0] in_mem_data,
  input  logic        in_issue_stall,
  output logic        out_inst_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_inst_pc,
  input  logic        in_rob_misbranch,
  input  logic [31:0] in_rob_newpc
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_ce_q, mem_ce_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic        hit_c;
  logic [31:0] hit_data_c;
  logic        fill_c;

  // A completion only lands when enabled, waiting, and not flushed the same cycle.
  assign fill_c = !rst && rdy && (state_q == ST_WAIT) && in_mem_ce && !in_rob_misbranch;

`ifdef FETCHER_ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 16 - IDX_W;

  logic [31:0]             data_q [ICACHE_LINES];
  logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] valid_q;
  logic [IDX_W-1:0]        lu_idx_c;
  logic [IDX_W-1:0]        fill_idx_c;

  assign lu_idx_c   = pc_q[IDX_W+1:2];
  assign fill_idx_c = mem_addr_q[IDX_W+1:2];
  assign hit_c      = valid_q[lu_idx_c] && (tag_q[lu_idx_c] == pc_q[17:IDX_W+2]);
  assign hit_data_c = data_q[lu_idx_c];

  // Valid bits clear on reset only; a flush leaves cached lines intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_c) begin
      valid_q[fill_idx_c] <= 1'b1;
    end
  end

  // Line payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      data_q[fill_idx_c] <= in_mem_data;
      tag_q[fill_idx_c]  <= mem_addr_q[17:IDX_W+2];
    end
  end
`else
  logic [31:0] buf_data_q;
  logic [15:0] buf_tag_q;
  logic        buf_valid_q;
  logic        unused_lines_c;

  // Line count has no meaning for the single-entry buffer.
  assign unused_lines_c = (ICACHE_LINES != 0);

  assign hit_c      = buf_valid_q && (buf_tag_q == pc_q[17:2]);
  assign hit_data_c = buf_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
    end else if (fill_c) begin
      buf_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_c) begin
      buf_data_q <= in_mem_data;
      buf_tag_q  <= mem_addr_q[17:2];
    end
  end
`endif

  // State and registered outputs; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      mem_ce_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_ce_q     <= mem_ce_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Next state: misbranch always returns to IDLE so the redirected PC is looked up first.
  always_comb begin
    state_d = state_q;
    if (in_rob_misbranch) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (!hit_c)    state_d = ST_WAIT;
        ST_WAIT: if (in_mem_ce) state_d = ST_IDLE;
        default:                state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of PC and outputs; pulses default low every cycle.
  always_comb begin
    pc_d         = pc_q;
    mem_ce_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (in_rob_misbranch) begin
      pc_d = in_rob_newpc;
    end else if (state_q == ST_IDLE) begin
      if (!hit_c) begin
        // Miss is requested even under stall so the fill overlaps the stall.
        mem_ce_d   = 1'b1;
        mem_addr_d = pc_q;
      end else if (!in_issue_stall) begin
        inst_valid_d = 1'b1;
        inst_d       = hit_data_c;
        inst_pc_d    = pc_q;
        pc_d         = pc_q + 32'd4;
      end
    end
  end

  assign out_mem_ce     = mem_ce_q;
  assign out_mem_addr   = mem_addr_q;
  assign out_inst_valid = inst_valid_q;
  assign out_inst       = inst_q;
  assign out_inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetcher_icache.sv
// Directed bench for fetcher_icache: a small memory-controller model answers
// each request LAT cycles later; deliveries and requests are logged per cycle
// and compared against hand-computed addresses, words and cycle offsets.
module tb_fetcher_icache;

  localparam int unsigned LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        out_mem_ce;
  logic [31:0] out_mem_addr;
  logic        in_mem_ce;
  logic [31:0] in_mem_data;
  logic        in_issue_stall;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_inst_pc;
  logic        in_rob_misbranch;
  logic [31:0] in_rob_newpc;

  fetcher_icache #(
    .ICACHE_LINES(256),
    .RESET_PC    (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .out_mem_ce      (out_mem_ce),
    .out_mem_addr    (out_mem_addr),
    .in_mem_ce       (in_mem_ce),
    .in_mem_data     (in_mem_data),
    .in_issue_stall  (in_issue_stall),
    .out_inst_valid  (out_inst_valid),
    .out_inst        (out_inst),
    .out_inst_pc     (out_inst_pc),
    .in_rob_misbranch(in_rob_misbranch),
    .in_rob_newpc    (in_rob_newpc)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int cyc;

  // Memory controller model state.
  logic        pend;
  int          cnt;
  logic [31:0] pend_addr;
  int          fill_cyc;

  // Per-cycle logs.
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] del_pc_q[$];
  logic [31:0] del_inst_q[$];
  int          del_cyc_q[$];
  logic        prev_valid;
  logic [31:0] prev_pc;

  // Memory image: word 0 is a NOP, every other word is {~addr[15:0], addr[15:0]}.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_cyc_q.delete();
    del_pc_q.delete();
    del_inst_q.delete();
    del_cyc_q.delete();
  endtask

  // One clock cycle: model drives in_mem_* for the current cycle, then outputs
  // of the next cycle are sampled 1 time unit after the edge.
  task automatic step();
    in_mem_ce   = 1'b0;
    in_mem_data = 32'h0;
    if (rst) begin
      pend = 1'b0;
    end else if (!rdy) begin
      // Frozen controller keeps presenting its completion; it must not be taken.
      if (pend && cnt == 0) begin
        in_mem_ce   = 1'b1;
        in_mem_data = 32'hDEAD_BEEF;
      end
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          in_mem_ce   = 1'b1;
          in_mem_data = mem_word(pend_addr);
          pend        = 1'b0;
          fill_cyc    = cyc;
        end else begin
          cnt--;
        end
      end
      if (out_mem_ce) begin
        check_eq("one_outstanding", 32'(pend), 32'h0);
        pend      = 1'b1;
        pend_addr = out_mem_addr;
        cnt       = LAT - 1;
      end
      if (in_rob_misbranch) pend = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (out_mem_ce) begin
      req_addr_q.push_back(out_mem_addr);
      req_cyc_q.push_back(cyc);
    end
    if (out_inst_valid) begin
      if (prev_valid) check_eq("no_repeat_pc", 32'(out_inst_pc == prev_pc), 32'h0);
      del_pc_q.push_back(out_inst_pc);
      del_inst_q.push_back(out_inst);
      del_cyc_q.push_back(cyc);
    end
    prev_valid = out_inst_valid;
    prev_pc    = out_inst_pc;
  endtask

  task automatic redirect(input logic [31:0] pc);
    in_rob_misbranch = 1'b1;
    in_rob_newpc     = pc;
    step();
    in_rob_misbranch = 1'b0;
  endtask

  task automatic run_until_del(input int n, input int budget);
    int k;
    k = 0;
    while (del_pc_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (del_pc_q.size() < n) check_eq("del_timeout", 32'(del_pc_q.size()), 32'(n));
  endtask

  // Advance until the model's completion is due in the current cycle.
  task automatic run_until_due(input int budget);
    int k;
    k = 0;
    while (!(pend && cnt == 0) && k < budget) begin
      step();
      k++;
    end
    if (!(pend && cnt == 0)) check_eq("due_timeout", 32'(pend), 32'h1);
  endtask

  initial begin
    logic [31:0] loop_inst [4];
    int c0;
    int m;
    int s;
    int f;
    int r;
    loop_inst = '{32'hFEFF_0100, 32'hFEFB_0104, 32'hFEF7_0108, 32'hFEF3_010C};

    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    pend = 1'b0;
    cnt = 0;
    pend_addr = 32'h0;
    fill_cyc = 0;
    prev_valid = 1'b0;
    prev_pc = 32'h0;
    rst = 1'b1;
    rdy = 1'b1;
    in_issue_stall = 1'b0;
    in_rob_misbranch = 1'b0;
    in_rob_newpc = 32'h0;
    in_mem_ce = 1'b0;
    in_mem_data = 32'h0;

    // Reset values.
    repeat (3) step();
    check_eq("rst_mem_ce", 32'(out_mem_ce), 32'h0);
    check_eq("rst_mem_addr", out_mem_addr, 32'h0);
    check_eq("rst_inst_valid", 32'(out_inst_valid), 32'h0);
    check_eq("rst_inst", out_inst, 32'h0);
    check_eq("rst_inst_pc", out_inst_pc, 32'h0);

    // Cold miss at RESET_PC: request next cycle, fill LAT later, delivery fill+2.
    clear_logs();
    rst = 1'b0;
    c0 = cyc;
    run_until_del(1, 30);
    check_eq("cold_req_count", 32'(req_addr_q.size()), 32'd1);
    check_eq("cold_req_addr", req_addr_q[0], 32'h0);
    check_eq("cold_req_cyc", 32'(req_cyc_q[0]), 32'(c0 + 1));
    check_eq("cold_fill_lat", 32'(fill_cyc - req_cyc_q[0]), 32'd6);
    check_eq("cold_del_after_fill", 32'(del_cyc_q[0] - fill_cyc), 32'd2);
    check_eq("cold_del_pc", del_pc_q[0], 32'h0);
    check_eq("cold_del_inst", del_inst_q[0], 32'h0000_0013);

    // Loop of 4 words at 0x100, first pass: every word misses.
    clear_logs();
    redirect(32'h100);
    run_until_del(4, 80);
    check_eq("loop1_req_count", 32'(req_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("loop1_pc", del_pc_q[i], 32'h100 + 32'(4 * i));
      check_eq("loop1_inst", del_inst_q[i], loop_inst[i]);
    end

    // Second pass of the loop.
    clear_logs();
    m = cyc;
    redirect(32'h100);
    run_until_del(4, 80);
`ifdef FETCHER_ICACHE_EN
    check_eq("loop2_req_count", 32'(req_addr_q.size()), 32'd0);
    check_eq("loop2_first_cyc", 32'(del_cyc_q[0]), 32'(m + 2));
    check_eq("loop2_burst", 32'(del_cyc_q[3] - del_cyc_q[0]), 32'd3);
`else
    check_eq("loop2_req_count", 32'(req_addr_q.size()), 32'd4);
`endif
    for (int i = 0; i < 4; i++) begin
      check_eq("loop2_pc", del_pc_q[i], 32'h100 + 32'(4 * i));
      check_eq("loop2_inst", del_inst_q[i], loop_inst[i]);
    end

    // Stall at 0x104: nothing delivered while stalled, PC holds.
    clear_logs();
    in_issue_stall = 1'b1;
    redirect(32'h104);
    repeat (11) step();
    check_eq("stall_no_del", 32'(del_pc_q.size()), 32'd0);
    in_issue_stall = 1'b0;
    s = cyc;
    run_until_del(2, 40);
    check_eq("stall_resume_pc", del_pc_q[0], 32'h104);
    check_eq("stall_resume_inst", del_inst_q[0], 32'hFEFB_0104);
    check_eq("stall_resume_cyc", 32'(del_cyc_q[0]), 32'(s + 1));
    check_eq("stall_next_pc", del_pc_q[1], 32'h108);
    check_eq("stall_next_inst", del_inst_q[1], 32'hFEF7_0108);

    // Misbranch to 0x200 in the same cycle as the fill for 0x10.
    clear_logs();
    redirect(32'h10);
    run_until_due(40);
    clear_logs();
    f = cyc;
    redirect(32'h200);
    run_until_del(1, 40);
    check_eq("flush_req_count", 32'(req_addr_q.size()), 32'd1);
    check_eq("flush_req_addr", req_addr_q[0], 32'h200);
    // Lookup of the new PC happens in f+1, so its pulse is visible at f+2.
    check_eq("flush_req_cyc", 32'(req_cyc_q[0]), 32'(f + 2));
    check_eq("flush_del_pc", del_pc_q[0], 32'h200);
    check_eq("flush_del_inst", del_inst_q[0], 32'hFDFF_0200);
    // The dropped fill must not have validated 0x10.
    clear_logs();
    redirect(32'h10);
    run_until_del(1, 40);
    check_eq("dropped_req_count", 32'(req_addr_q.size()), 32'd1);
    check_eq("dropped_req_addr", req_addr_q[0], 32'h10);
    check_eq("dropped_del_inst", del_inst_q[0], 32'hFFEF_0010);

    // Aliasing from a cold cache: 0x0, 0x400, 0x0 share index 0.
    rst = 1'b1;
    repeat (2) step();
    clear_logs();
    rst = 1'b0;
    run_until_del(1, 30);
    redirect(32'h400);
    run_until_del(2, 30);
    redirect(32'h0);
    run_until_del(3, 30);
    check_eq("alias_req_count", 32'(req_addr_q.size()), 32'd3);
    check_eq("alias_req0", req_addr_q[0], 32'h0);
    check_eq("alias_req1", req_addr_q[1], 32'h400);
    check_eq("alias_req2", req_addr_q[2], 32'h0);
    check_eq("alias_inst0", del_inst_q[0], 32'h0000_0013);
    check_eq("alias_inst1", del_inst_q[1], 32'hFBFF_0400);
    check_eq("alias_inst2", del_inst_q[2], 32'h0000_0013);

    // rdy low for 5 cycles in WAIT while a completion is presented.
    clear_logs();
    redirect(32'h300);
    run_until_due(40);
    rdy = 1'b0;
    repeat (5) begin
      step();
      check_eq("hold_mem_ce", 32'(out_mem_ce), 32'h0);
      check_eq("hold_mem_addr", out_mem_addr, 32'h300);
      check_eq("hold_inst_valid", 32'(out_inst_valid), 32'h0);
      check_eq("hold_inst", out_inst, 32'h0000_0013);
      check_eq("hold_inst_pc", out_inst_pc, 32'h0);
    end
    rdy = 1'b1;
    r = cyc;
    run_until_del(1, 20);
    check_eq("hold_req_count", 32'(req_addr_q.size()), 32'd1);
    check_eq("hold_del_cyc", 32'(del_cyc_q[0]), 32'(r + 2));
    check_eq("hold_del_pc", del_pc_q[0], 32'h300);
    check_eq("hold_del_inst", del_inst_q[0], 32'hFCFF_0300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
